// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared defaults and slot-state encoding for the IO write decoder
package io_pkg;

  localparam int IO_WORD_WIDTH      = 36;
  localparam int IO_ADDR_WIDTH      = 10;
  localparam int IO_PORT_COUNT      = 8;
  localparam int IO_PORT_BASE_ADDR  = 1016;
  localparam int IO_PORT_ADDR_WIDTH = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/io_write_port_slot.sv
// rtl/io_write_port_slot.sv - single-entry holding slot for one write port
module io_write_port_slot
  import io_pkg::*;
#(
  parameter int WORD_WIDTH = IO_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  blocked_o
);

  slot_state_e           state_q, state_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (wr_i) begin
          state_d = FULL;
          data_d  = data_i;
        end
      end
      FULL: begin
        // A consume on the same edge frees the slot for the incoming write.
        if (ready_i && wr_i) begin
          data_d = data_i;
        end else if (ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = (state_q == FULL);
  assign data_o    = data_q;
  assign blocked_o = wr_i && (state_q == FULL) && !ready_i;

endmodule

// File: rtl/io_write_decode.sv
// rtl/io_write_decode.sv - decodes pipeline writes onto a bank of held write ports
// Optional sticky overflow flag under IO_WRITE_DECODE_ERR_EN.
module io_write_decode
  import io_pkg::*;
#(
  parameter int WORD_WIDTH            = IO_WORD_WIDTH,
  parameter int ADDR_WIDTH            = IO_ADDR_WIDTH,
  parameter int WRITE_PORT_COUNT      = IO_PORT_COUNT,
  parameter int WRITE_PORT_BASE_ADDR  = IO_PORT_BASE_ADDR,
  parameter int WRITE_PORT_ADDR_WIDTH = IO_PORT_ADDR_WIDTH
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 write_en,
  input  logic [ADDR_WIDTH-1:0]                write_addr,
  input  logic [WORD_WIDTH-1:0]                write_data,
  output logic                                 write_blocked,
  output logic [WRITE_PORT_COUNT*WORD_WIDTH-1:0] port_data_out,
  output logic [WRITE_PORT_COUNT-1:0]          port_valid,
  input  logic [WRITE_PORT_COUNT-1:0]          port_ready
`ifdef IO_WRITE_DECODE_ERR_EN
  ,
  output logic                                 err_overflow,
  input  logic                                 err_clear
`endif
);

  logic [31:0]                      offset;
  logic                             hit;
  logic [WRITE_PORT_ADDR_WIDTH-1:0] port_idx;
  logic [WRITE_PORT_COUNT-1:0]      slot_blocked;

  // Widened compare so addresses below the base never alias into range.
  assign offset   = 32'(write_addr) - 32'(WRITE_PORT_BASE_ADDR);
  assign hit      = (32'(write_addr) >= 32'(WRITE_PORT_BASE_ADDR)) &&
                    (offset < 32'(WRITE_PORT_COUNT));
  assign port_idx = offset[WRITE_PORT_ADDR_WIDTH-1:0];

  for (genvar i = 0; i < WRITE_PORT_COUNT; i++) begin : g_slot
    io_write_port_slot #(
      .WORD_WIDTH(WORD_WIDTH)
    ) u_slot (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_i     (write_en && hit && (port_idx == WRITE_PORT_ADDR_WIDTH'(i))),
      .data_i   (write_data),
      .ready_i  (port_ready[i]),
      .valid_o  (port_valid[i]),
      .data_o   (port_data_out[i*WORD_WIDTH +: WORD_WIDTH]),
      .blocked_o(slot_blocked[i])
    );
  end

  assign write_blocked = |slot_blocked;

`ifdef IO_WRITE_DECODE_ERR_EN
  logic err_q, err_d;

  // Set wins over clear so a drop in the clearing cycle is not lost.
  always_comb begin
    err_d = err_q;
    if (write_blocked) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_overflow = err_q;
`endif

endmodule

// File: tb/tb_io_write_decode.sv
// tb/tb_io_write_decode.sv - randomized self-checking bench for io_write_decode
module tb_io_write_decode;

  localparam int W    = 36;
  localparam int AW   = 10;
  localparam int N    = 8;
  localparam int BASE = 1016;
  localparam int CW   = N * W;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           write_en;
  logic [AW-1:0]  write_addr;
  logic [W-1:0]   write_data;
  logic           write_blocked;
  logic [CW-1:0]  port_data_out;
  logic [N-1:0]   port_valid;
  logic [N-1:0]   port_ready;
  logic           err_clear;
`ifdef IO_WRITE_DECODE_ERR_EN
  logic           err_overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit           m_valid [N];
  logic [W-1:0] m_data  [N];
  bit           m_err;

  always #5 clock = ~clock;

  io_write_decode #(
    .WORD_WIDTH(W), .ADDR_WIDTH(AW), .WRITE_PORT_COUNT(N),
    .WRITE_PORT_BASE_ADDR(BASE), .WRITE_PORT_ADDR_WIDTH(3)
  ) dut (
    .clock(clock), .reset_n(reset_n), .write_en(write_en),
    .write_addr(write_addr), .write_data(write_data),
    .write_blocked(write_blocked), .port_data_out(port_data_out),
    .port_valid(port_valid), .port_ready(port_ready)
`ifdef IO_WRITE_DECODE_ERR_EN
    , .err_overflow(err_overflow), .err_clear(err_clear)
`endif
  );

  task automatic check_eq(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_data[i]  = '0;
    end
    m_err = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [CW-1:0] exp_bus;
    logic [N-1:0]  exp_v;
    for (int i = 0; i < N; i++) begin
      exp_bus[i*W +: W] = m_data[i];
      exp_v[i]          = m_valid[i];
    end
    check_eq({tag, " port_valid"}, CW'(port_valid), CW'(exp_v));
    check_eq({tag, " port_data"}, port_data_out, exp_bus);
`ifdef IO_WRITE_DECODE_ERR_EN
    check_eq({tag, " err_overflow"}, CW'(err_overflow), CW'(m_err));
`endif
  endtask

  // One clock: drive at negedge, check the combinational drop flag, then the registered state.
  task automatic drive(input string tag, input bit we, input int addr,
                       input logic [W-1:0] d, input logic [N-1:0] rdy);
    int  a;
    bit  hit;
    bit  blk;
    int  p;
    @(negedge clock);
    write_en   = we;
    write_addr = AW'(addr);
    write_data = d;
    port_ready = rdy;
    a   = addr % (1 << AW);
    hit = we && (a >= BASE) && (a < BASE + N);
    p   = a - BASE;
    blk = hit && m_valid[p] && !rdy[p];
    #1;
    check_eq({tag, " write_blocked"}, CW'(write_blocked), CW'(blk));
    for (int i = 0; i < N; i++)
      if (m_valid[i] && rdy[i]) m_valid[i] = 0;
    if (hit && !blk) begin
      m_valid[p] = 1;
      m_data[p]  = d;
    end
    if (blk) m_err = 1;
    else if (err_clear) m_err = 0;
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    reset_n    = 1'b0;
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
    port_ready = '0;
    err_clear  = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    check_eq("reset write_blocked", CW'(write_blocked), '0);
    @(negedge clock);
    reset_n = 1'b1;

    drive("first_write", 1, 1016, 36'h123, '0);
    drive("fill_p3", 1, 1019, 36'h11, '0);
    drive("blocked_p3", 1, 1019, 36'h5A, '0);
    err_clear = 1'b1;
    drive("err_clear", 0, 0, '0, '0);
    err_clear = 1'b0;
    drive("swap_p3", 1, 1019, 36'h22, 8'h08);
    drive("below_base", 1, 1015, 36'hABC, '0);
    drive("wrap_1024", 1, 1024, 36'hDEF, '0);
    for (int i = 0; i < N; i++)
      drive("fill_all", 1, BASE + i, W'(36'h100 + i), '0);
    drive("drain_p5", 0, 0, '0, 8'h20);
    drive("ready_on_empty", 1, 1021, 36'hF00D, 8'h20);

    @(posedge clock);
    #2;
    write_en   = 1'b1;
    write_addr = AW'(BASE);
    reset_n    = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    check_eq("async_reset write_blocked", CW'(write_blocked), '0);
    @(negedge clock);
    write_en = 1'b0;
    reset_n  = 1'b1;
    drive("post_reset_write", 1, 1018, 36'hCAFE, '0);

    for (int k = 0; k < 400; k++) begin
      err_clear = ($urandom_range(0, 7) == 0);
      drive("random", $urandom_range(0, 3) != 0, 1010 + $urandom_range(0, 15),
            W'({$urandom, $urandom}), N'($urandom & $urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
